// File: rtl/win3x3_stream_ctrl.sv
// win3x3_stream_ctrl: feeds pixels to external line buffers and assembles 3x3 windows from their taps
module win3x3_stream_ctrl #(
   parameter logic [10:0] PIC_WIDTH  = 11'd250,
   parameter logic [10:0] PIC_HEIGHT = 11'd250,
   parameter int          WIDTH      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   pix_in,
   input  logic               pix_in_valid,
   output logic               pix_in_ready,
   output logic               lb_rst_fifo,
   input  logic               lb_fifo_rst_busy,
   output logic [WIDTH-1:0]   lb_din,
   output logic               lb_valid_in,
   output logic               lb_rd_en_all,
   input  logic [WIDTH-1:0]   lb_dout1,
   input  logic [WIDTH-1:0]   lb_dout2,
   input  logic [WIDTH-1:0]   lb_dout3,
   output logic [9*WIDTH-1:0] win_out,
   output logic               win_valid,
   output logic [8:0]         win_x,
   output logic [8:0]         win_y,
   output logic               frame_done
);
   typedef enum logic [2:0] {IDLE, FRST, WAIT_BUSY, STREAM, DRAIN, DONE} state_t;
   localparam logic [16:0] FRAME_PIX = 17'(PIC_WIDTH) * 17'(PIC_HEIGHT);
   localparam logic [16:0] TWO_ROWS  = 17'(PIC_WIDTH) << 1;
   state_t             state, nxt;
   logic [2:0]         frst_cnt;
   logic               wait_done;
   logic [16:0]        pix_cnt;
   logic [1:0]         drain_cnt;
   logic               xfer, clr;
   logic               tap_stb;
   logic [10:0]        tap_col, tap_row;
   logic [3*WIDTH-1:0] col0, col1, col2;
   // next-state decode and handshake/status outputs
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = start ? FRST : IDLE;
         FRST:      nxt = frst_cnt == 3'd7 ? WAIT_BUSY : FRST;
         WAIT_BUSY: nxt = (wait_done && !lb_fifo_rst_busy) ? STREAM : WAIT_BUSY;
         STREAM:    nxt = (xfer && pix_cnt == FRAME_PIX - 17'd1) ? DRAIN : STREAM;
         DRAIN:     nxt = drain_cnt == 2'd2 ? DONE : DRAIN;
         DONE:      nxt = IDLE;
         default:   nxt = IDLE;
      endcase
      pix_in_ready = state == STREAM;
      xfer         = pix_in_ready && pix_in_valid;
      clr          = state == IDLE && start;
      lb_valid_in  = xfer;
      lb_din       = xfer ? pix_in : '0;
      lb_rd_en_all = xfer && pix_cnt >= TWO_ROWS;
      lb_rst_fifo  = !(state == IDLE || state == FRST);
      frame_done   = state == DONE;
   end
   // window is row-major with the oldest row (dout3) on top and the newest column on the right
   always_comb begin
      win_out = {col0[3*WIDTH-1 -: WIDTH], col1[3*WIDTH-1 -: WIDTH], col2[3*WIDTH-1 -: WIDTH],
                 col0[2*WIDTH-1 -: WIDTH], col1[2*WIDTH-1 -: WIDTH], col2[2*WIDTH-1 -: WIDTH],
                 col0[WIDTH-1:0],          col1[WIDTH-1:0],          col2[WIDTH-1:0]};
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end
   // sequencing counters: fifo reset length, busy wait, accepted pixels, drain length
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
         frst_cnt  <= '0;
         wait_done <= 1'b0;
         pix_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         if (state == FRST)      frst_cnt  <= frst_cnt + 3'd1;
         if (state == WAIT_BUSY) wait_done <= 1'b1;
         if (xfer)               pix_cnt   <= pix_cnt + 17'd1;
         if (state == DRAIN)     drain_cnt <= drain_cnt + 2'd1;
      end
   end
   // tap tracking and window shift; a window is only complete once three columns of the same line are in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
         tap_stb   <= 1'b0;
         tap_col   <= '0;
         tap_row   <= '0;
         col0      <= '0;
         col1      <= '0;
         col2      <= '0;
         win_valid <= 1'b0;
         win_x     <= '0;
         win_y     <= '0;
      end else begin
         tap_stb   <= lb_rd_en_all;
         win_valid <= tap_stb && tap_col >= 11'd2;
         if (tap_stb) begin
            col0    <= col1;
            col1    <= col2;
            col2    <= {lb_dout3, lb_dout2, lb_dout1};
            tap_col <= tap_col == PIC_WIDTH - 11'd1 ? '0 : tap_col + 11'd1;
            tap_row <= tap_col == PIC_WIDTH - 11'd1 ? tap_row + 11'd1 : tap_row;
            win_x   <= 9'(tap_col - 11'd1);
            win_y   <= 9'(tap_row + 11'd1);
         end
      end
   end
endmodule

// File: tb/tb_win3x3_stream_ctrl.sv
// tb_win3x3_stream_ctrl: random-stimulus bench with an image-level window model and line-buffer emulation
module tb_win3x3_stream_ctrl;
   localparam int W  = 20;
   localparam int H  = 12;
   localparam int NW = (W - 2) * (H - 2);
   logic        clk, rst_n, start, pix_in_valid, busy;
   logic [7:0]  pix_in, lb_din, lb_dout1, lb_dout2, lb_dout3;
   logic        pix_in_ready, lb_rst_fifo, lb_valid_in, lb_rd_en_all, win_valid, frame_done;
   logic [71:0] win_out;
   logic [8:0]  win_x, win_y;
   win3x3_stream_ctrl #(.PIC_WIDTH(11'd20), .PIC_HEIGHT(11'd12), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pix_in(pix_in), .pix_in_valid(pix_in_valid),
      .pix_in_ready(pix_in_ready), .lb_rst_fifo(lb_rst_fifo), .lb_fifo_rst_busy(busy),
      .lb_din(lb_din), .lb_valid_in(lb_valid_in), .lb_rd_en_all(lb_rd_en_all),
      .lb_dout1(lb_dout1), .lb_dout2(lb_dout2), .lb_dout3(lb_dout3), .win_out(win_out),
      .win_valid(win_valid), .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
   );
   logic [7:0]  img [W*H];
   logic [71:0] exp_win [NW];
   int          exp_x [NW];
   int          exp_y [NW];
   int          n_chk = 0, n_fail = 0;
   int          cyc = 0, last_cyc = 0, xfer = 0, wi = 0, done_cnt = 0, cur_idx = 0;
   logic        rd_pend = 1'b0, s_ready, s_rst_fifo, s_hs, rd_m1, rd_0;
   logic [71:0] f_win;
   int          f_x, f_y, l_x, l_y;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   // line buffer: taps for the accepted pixel appear the cycle after a read, junk otherwise
   always @(posedge clk) begin
      if (rd_pend && cur_idx >= 2 * W) begin
         lb_dout1 <= img[cur_idx];
         lb_dout2 <= img[cur_idx - W];
         lb_dout3 <= img[cur_idx - 2 * W];
      end else begin
         lb_dout1 <= 8'($urandom);
         lb_dout2 <= 8'($urandom);
         lb_dout3 <= 8'($urandom);
      end
   end
   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   task automatic monitor();
      cyc++;
      rd_pend    = 1'b0;
      s_ready    = pix_in_ready;
      s_rst_fifo = lb_rst_fifo;
      s_hs       = pix_in_valid && pix_in_ready;
      if (!rst_n) begin
         xfer = 0;
         wi   = 0;
         chk("rst_pix_in_ready", pix_in_ready, 0);
         chk("rst_lb_valid_in", lb_valid_in, 0);
         chk("rst_lb_rd_en_all", lb_rd_en_all, 0);
         chk("rst_lb_din", lb_din, 0);
         chk("rst_lb_rst_fifo", lb_rst_fifo, 0);
         chk("rst_win_out", win_out, 0);
         chk("rst_win_valid", win_valid, 0);
         chk("rst_win_x", win_x, 0);
         chk("rst_win_y", win_y, 0);
         chk("rst_frame_done", frame_done, 0);
      end else begin
         if (xfer >= W * H) chk("ready_after_last_pixel", pix_in_ready, 0);
         chk("lb_valid_in", lb_valid_in, s_hs);
         chk("lb_rd_en_all", lb_rd_en_all, s_hs && xfer >= 2 * W);
         if (s_hs) begin
            chk("lb_din", lb_din, pix_in);
            if (xfer == 2 * W - 1) rd_m1 = lb_rd_en_all;
            if (xfer == 2 * W) rd_0 = lb_rd_en_all;
            cur_idx  = xfer;
            xfer++;
            last_cyc = cyc;
         end
         rd_pend = lb_rd_en_all;
         if (win_valid) begin
            if (wi >= NW) begin
               n_chk++;
               n_fail++;
               $display("FAIL extra_window: got window %0d x=%0d y=%0d, only %0d expected", wi, win_x, win_y, NW);
            end else begin
               chk("win_out", win_out, exp_win[wi]);
               chk("win_x", win_x, exp_x[wi]);
               chk("win_y", win_y, exp_y[wi]);
               if (wi == 0) begin
                  f_win = win_out;
                  f_x   = win_x;
                  f_y   = win_y;
               end
               l_x = win_x;
               l_y = win_y;
               wi++;
            end
         end
         if (frame_done) begin
            done_cnt++;
            chk("frame_done_latency", cyc - last_cyc, 4);
            chk("windows_before_done", wi, NW);
         end
      end
   endtask
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask
   task automatic run_frame(input bit ramp, input int gap, input int hold, input int abort_at, input bit mid_start);
      int  lo, k, t, n, m;
      bit  hi, aborted;
      logic [71:0] w;
      for (int i = 0; i < W * H; i++) img[i] = ramp ? 8'(i % W + i / W) : 8'($urandom);
      m = 0;
      for (int y = 1; y < H - 1; y++)
         for (int x = 1; x < W - 1; x++) begin
            w = '0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++) w = {w[63:0], img[(y + dy) * W + x + dx]};
            exp_win[m] = w;
            exp_x[m]   = x;
            exp_y[m]   = y;
            m++;
         end
      xfer = 0; wi = 0; done_cnt = 0; rd_m1 = 1'bx; rd_0 = 1'bx;
      busy  = hold > 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      lo = 0; hi = 0; t = 0;
      while (!hi && t < 40) begin
         tick();
         t++;
         if (s_rst_fifo) hi = 1;
         else begin
            lo++;
            chk("ready_in_fifo_reset", s_ready, 0);
         end
      end
      chk("fifo_reset_low_cycles", lo, 8);
      if (hold == 0) begin
         k = s_ready ? 0 : 1;
         t = 0;
         while (!s_ready && t < 40) begin
            tick();
            t++;
            if (!s_ready) k++;
         end
         chk("wait_busy_min_cycles", k, 2);
      end else begin
         for (int i = 0; i < hold; i++) begin
            tick();
            chk("ready_while_busy", s_ready, 0);
         end
         busy = 1'b0;
         tick();
         chk("ready_at_busy_fall", s_ready, 0);
         tick();
         chk("ready_after_busy_fall", s_ready, 1);
      end
      n = 0; t = 0; aborted = 0;
      while (n < W * H && t < 8 * W * H && !aborted) begin
         if (n == abort_at) aborted = 1;
         else begin
            pix_in_valid = $urandom_range(99) >= gap;
            pix_in       = img[n];
            start        = mid_start && n == W * H / 2;
            tick();
            t++;
            if (s_hs) n++;
         end
      end
      pix_in_valid = 1'b0;
      start        = 1'b0;
      if (aborted) begin
         rst_n = 1'b0;
         repeat (3) tick();
         rst_n = 1'b1;
         repeat (12) tick();
         chk("no_frame_done_after_abort", done_cnt, 0);
      end else begin
         chk("stream_complete", n, W * H);
         t = 0;
         while (done_cnt == 0 && t < 30) begin
            tick();
            t++;
         end
         repeat (4) tick();
         chk("frame_done_once", done_cnt, 1);
         chk("window_count", wi, NW);
      end
   endtask
   initial begin
      rst_n = 1'b0; start = 1'b0; pix_in_valid = 1'b0; pix_in = '0; busy = 1'b0;
      lb_dout1 = '0; lb_dout2 = '0; lb_dout3 = '0;
      @(posedge clk);
      #1;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      run_frame(1'b1, 0, 11, -1, 1'b0);
      chk("ramp_first_window", f_win, 72'h000102010203020304);
      chk("ramp_first_x", f_x, 1);
      chk("ramp_first_y", f_y, 1);
      chk("ramp_first_centre", f_win[39:32], 2);
      chk("ramp_last_x", l_x, 18);
      chk("ramp_last_y", l_y, 10);
      chk("ramp_window_total", wi, 180);
      chk("rd_en_pixel_2w_minus_1", rd_m1, 0);
      chk("rd_en_pixel_2w", rd_0, 1);
      run_frame(1'b1, 30, 0, -1, 1'b0);
      chk("gap_first_window", f_win, 72'h000102010203020304);
      chk("gap_last_x", l_x, 18);
      run_frame(1'b0, 30, 3, W * H / 2, 1'b0);
      run_frame(1'b0, 20, 0, -1, 1'b1);
      chk("restart_window_total", wi, 180);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
